// File: rtl/ssd_hex_capture.sv
// rtl/ssd_hex_capture.sv - recovers hex digits from a multiplexed active-low seven-segment bus
// Optional feature: BLANK_DETECT_EN (all-segments-off pattern commits as a legal blank).
module ssd_hex_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [0:6]            i_seg,
    input  logic [DIGITS-1:0]     i_dig,
    output logic [4*DIGITS-1:0]   o_hex,
    output logic [DIGITS-1:0]     o_valid,
    output logic [DIGITS-1:0]     o_err,
    output logic                  o_upd,
    output logic [2:0]            o_upd_idx
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {SETTLE, COMMIT, HOLD} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [0:6]            r_s_seg;
    logic [0:6]            r_p_seg;
    logic [DIGITS-1:0]     r_s_dig;
    logic [DIGITS-1:0]     r_p_dig;
    logic [CW-1:0]         r_cnt;
    logic [4*DIGITS-1:0]   r_hex;
    logic [DIGITS-1:0]     r_valid;
    logic [DIGITS-1:0]     r_err;
    logic                  r_upd;
    logic [2:0]            r_upd_idx;
    logic                  w_changed;
    logic                  w_commit;
    logic [2:0]            w_idx;
    logic [4:0]            w_dec;

    // Returns {match, nibble}; match=0 for any pattern outside the table.
    function automatic logic [4:0] decode(input logic [0:6] s);
        case (s)
            7'b0000001: decode = {1'b1, 4'h0};
            7'b1001111: decode = {1'b1, 4'h1};
            7'b0010010: decode = {1'b1, 4'h2};
            7'b0000110: decode = {1'b1, 4'h3};
            7'b1001100: decode = {1'b1, 4'h4};
            7'b0100100: decode = {1'b1, 4'h5};
            7'b0100000: decode = {1'b1, 4'h6};
            7'b0001111: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0001100: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b1100000: decode = {1'b1, 4'hB};
            7'b0110001: decode = {1'b1, 4'hC};
            7'b1000010: decode = {1'b1, 4'hD};
            7'b0110000: decode = {1'b1, 4'hE};
            7'b0111000: decode = {1'b1, 4'hF};
            default:    decode = 5'h00;
        endcase
    endfunction

    assign w_changed = (r_s_seg != r_p_seg) || (r_s_dig != r_p_dig);
    assign w_dec     = decode(r_s_seg);

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_s_dig[i]) w_idx = 3'(i);
        end
    end

    // S==P is also required so a change landing on the saturating edge cannot commit the new pattern early.
    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            SETTLE: begin
                if (r_cnt == CNT_MAX && !w_changed && $onehot(r_s_dig)) begin
                    w_next   = COMMIT;
                    w_commit = 1'b1;
                end
            end
            COMMIT:  w_next = w_changed ? SETTLE : HOLD;
            HOLD:    if (w_changed) w_next = SETTLE;
            default: w_next = SETTLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= SETTLE;
            r_s_seg   <= '0;
            r_p_seg   <= '0;
            r_s_dig   <= '0;
            r_p_dig   <= '0;
            r_cnt     <= '0;
            r_hex     <= '0;
            r_valid   <= '0;
            r_err     <= '0;
            r_upd     <= 1'b0;
            r_upd_idx <= 3'd0;
        end else begin
            r_state   <= w_next;
            r_s_seg   <= i_seg;
            r_p_seg   <= r_s_seg;
            r_s_dig   <= i_dig;
            r_p_dig   <= r_s_dig;
            if (w_changed)             r_cnt <= CW'(1);
            else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
            r_upd     <= w_commit;
            r_upd_idx <= w_commit ? w_idx : 3'd0;
            for (int i = 0; i < DIGITS; i++) begin
                if (w_commit && r_s_dig[i]) begin
                    if (w_dec[4]) begin
                        r_hex[4*i +: 4] <= w_dec[3:0];
                        r_valid[i]      <= 1'b1;
                        r_err[i]        <= 1'b0;
                    end else begin
`ifdef BLANK_DETECT_EN
                        if (r_s_seg == 7'b1111111) begin
                            r_hex[4*i +: 4] <= 4'h0;
                            r_valid[i]      <= 1'b0;
                            r_err[i]        <= 1'b0;
                        end else begin
                            r_valid[i]      <= 1'b0;
                            r_err[i]        <= 1'b1;
                        end
`else
                        r_valid[i]      <= 1'b0;
                        r_err[i]        <= 1'b1;
`endif
                    end
                end
            end
        end
    end

    assign o_hex     = r_hex;
    assign o_valid   = r_valid;
    assign o_err     = r_err;
    assign o_upd     = r_upd;
    assign o_upd_idx = r_upd_idx;

endmodule

// File: tb/tb_ssd_hex_capture.sv
// tb/tb_ssd_hex_capture.sv - scoreboard bench for ssd_hex_capture
module tb_ssd_hex_capture;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;
    localparam int LAT    = STABLE + 2;   // edges from drive to visible UPD: sample edge + STABLE + 1

    logic                clk = 1'b0;
    logic                rst;
    logic [0:6]          seg;
    logic [DIGITS-1:0]   dig;
    logic [4*DIGITS-1:0] o_hex;
    logic [DIGITS-1:0]   o_valid;
    logic [DIGITS-1:0]   o_err;
    logic                o_upd;
    logic [2:0]          o_upd_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [0:6] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic [15:0] m_hex;
    logic [3:0]  m_valid;
    logic [3:0]  m_err;
    int exp_idx[$];
    int got_idx[$];
    int got_pos[$];

    ssd_hex_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .i_clk(clk), .i_rst(rst), .i_seg(seg), .i_dig(dig),
        .o_hex(o_hex), .o_valid(o_valid), .o_err(o_err),
        .o_upd(o_upd), .o_upd_idx(o_upd_idx));

    always #5 clk = ~clk;

    function automatic void predict(input logic [0:6] s, input logic [3:0] d);
        int idx = 0;
        logic hit = 1'b0;
        logic [3:0] nib = 4'h0;
        for (int i = 0; i < 4; i++) if (d[i]) idx = i;
        for (int n = 0; n < 16; n++) if (seg_tab[n] === s) begin hit = 1'b1; nib = 4'(n); end
        exp_idx.push_back(idx);
        if (hit) begin
            m_hex[4*idx +: 4] = nib; m_valid[idx] = 1'b1; m_err[idx] = 1'b0;
        end else begin
`ifdef BLANK_DETECT_EN
            if (s === 7'b1111111) begin
                m_hex[4*idx +: 4] = 4'h0; m_valid[idx] = 1'b0; m_err[idx] = 1'b0;
            end else begin
                m_valid[idx] = 1'b0; m_err[idx] = 1'b1;
            end
`else
            m_valid[idx] = 1'b0; m_err[idx] = 1'b1;
`endif
        end
    endfunction

    task automatic show(input logic [0:6] s, input logic [3:0] d, input int n);
        seg = s; dig = d;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            if (o_upd) begin got_idx.push_back(int'(o_upd_idx)); got_pos.push_back(c); end
        end
    endtask

    task automatic clear_sb();
        exp_idx.delete(); got_idx.delete(); got_pos.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; seg = 7'b1111111; dig = '0;
        repeat (3) @(posedge clk);
        #1;
        m_hex = '0; m_valid = '0; m_err = '0;
        n_checks++; if (o_hex !== 16'h0)    begin n_fail++; $display("FAIL reset_hex: got %h expected 0", o_hex); end
        n_checks++; if (o_valid !== 4'h0)   begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", o_valid); end
        n_checks++; if (o_err !== 4'h0)     begin n_fail++; $display("FAIL reset_err: got %b expected 0000", o_err); end
        n_checks++; if (o_upd !== 1'b0)     begin n_fail++; $display("FAIL reset_upd: got %b expected 0", o_upd); end
        n_checks++; if (o_upd_idx !== 3'd0) begin n_fail++; $display("FAIL reset_upd_idx: got %0d expected 0", o_upd_idx); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_sb();
        predict(7'b0010010, 4'b0001);
        show(7'b0010010, 4'b0001, 6);
        n_checks++; if (got_idx.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", got_idx.size()); end
        else begin
            n_checks++; if (got_pos[0] != LAT) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", got_pos[0], LAT); end
            n_checks++; if (got_idx[0] != exp_idx[0]) begin n_fail++; $display("FAIL single_idx: got %0d expected %0d", got_idx[0], exp_idx[0]); end
        end
        n_checks++; if (o_hex[3:0] !== 4'h2) begin n_fail++; $display("FAIL single_hex: got %h expected 2", o_hex[3:0]); end
        n_checks++; if (o_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %b expected 0001", o_valid); end
        n_checks++; if (o_err !== 4'b0000) begin n_fail++; $display("FAIL single_err: got %b expected 0000", o_err); end
    endtask

    task automatic test_scan();
        logic [3:0] vals [4] = '{4'h3, 4'hA, 4'hD, 4'hF};
        clear_sb();
        for (int i = 0; i < 4; i++) begin
            predict(seg_tab[vals[i]], 4'(1 << i));
            show(seg_tab[vals[i]], 4'(1 << i), 8);
        end
        n_checks++; if (got_idx.size() != exp_idx.size()) begin n_fail++; $display("FAIL scan_count: got %0d expected %0d", got_idx.size(), exp_idx.size()); end
        while (got_idx.size() > 0 && exp_idx.size() > 0) begin
            int g = got_idx.pop_front();
            int e = exp_idx.pop_front();
            n_checks++; if (g != e) begin n_fail++; $display("FAIL scan_idx: got %0d expected %0d", g, e); end
        end
        n_checks++; if (o_hex !== 16'hFDA3) begin n_fail++; $display("FAIL scan_hex: got %h expected fda3", o_hex); end
        n_checks++; if (o_valid !== 4'b1111) begin n_fail++; $display("FAIL scan_valid: got %b expected 1111", o_valid); end
        n_checks++; if (o_hex !== m_hex) begin n_fail++; $display("FAIL scan_model: got %h expected %h", o_hex, m_hex); end
    endtask

    task automatic test_toggle();
        clear_sb();
        for (int i = 0; i < 10; i++) show((i % 2 == 0) ? seg_tab[1] : seg_tab[7], 4'b0001, 2);
        n_checks++; if (got_idx.size() != 0) begin n_fail++; $display("FAIL toggle_count: got %0d expected 0", got_idx.size()); end
        n_checks++; if (o_hex !== m_hex) begin n_fail++; $display("FAIL toggle_hex: got %h expected %h", o_hex, m_hex); end
        n_checks++; if (o_valid !== m_valid || o_err !== m_err) begin n_fail++; $display("FAIL toggle_flags: got %b/%b expected %b/%b", o_valid, o_err, m_valid, m_err); end
    endtask

    task automatic test_bad_dig();
        clear_sb();
        show(seg_tab[8], 4'b0000, 10);
        show(seg_tab[8], 4'b0110, 10);
        n_checks++; if (got_idx.size() != 0) begin n_fail++; $display("FAIL baddig_count: got %0d expected 0", got_idx.size()); end
        n_checks++; if (o_hex !== m_hex || o_valid !== m_valid || o_err !== m_err) begin n_fail++; $display("FAIL baddig_outputs: got %h/%b/%b expected %h/%b/%b", o_hex, o_valid, o_err, m_hex, m_valid, m_err); end
    endtask

    task automatic test_unrecognised();
        clear_sb();
        predict(7'b1111110, 4'b0010);
        show(7'b1111110, 4'b0010, 8);
        n_checks++; if (got_idx.size() != 1 || got_idx[0] != 1) begin n_fail++; $display("FAIL unrec_upd: got %0d pulses expected 1 on digit 1", got_idx.size()); end
        n_checks++; if (o_err[1] !== 1'b1 || o_valid[1] !== 1'b0) begin n_fail++; $display("FAIL unrec_flags: got err=%b valid=%b expected err=1 valid=0", o_err[1], o_valid[1]); end
        n_checks++; if (o_hex[7:4] !== 4'hA) begin n_fail++; $display("FAIL unrec_hex: got %h expected a", o_hex[7:4]); end
        clear_sb();
        predict(7'b1111111, 4'b0010);
        show(7'b1111111, 4'b0010, 8);
        n_checks++; if (got_idx.size() != 1) begin n_fail++; $display("FAIL blank_upd: got %0d expected 1", got_idx.size()); end
        n_checks++; if (o_hex !== m_hex || o_valid !== m_valid || o_err !== m_err) begin n_fail++; $display("FAIL blank_outputs: got %h/%b/%b expected %h/%b/%b", o_hex, o_valid, o_err, m_hex, m_valid, m_err); end
    endtask

    task automatic test_redisplay();
        clear_sb();
        predict(seg_tab[5], 4'b0100);
        show(seg_tab[5], 4'b0100, 20);
        show(seg_tab[5], 4'b0000, 3);
        predict(seg_tab[5], 4'b0100);
        show(seg_tab[5], 4'b0100, 8);
        n_checks++; if (got_idx.size() != 2) begin n_fail++; $display("FAIL redisp_count: got %0d expected 2", got_idx.size()); end
        while (got_idx.size() > 0 && exp_idx.size() > 0) begin
            int g = got_idx.pop_front();
            int e = exp_idx.pop_front();
            n_checks++; if (g != e) begin n_fail++; $display("FAIL redisp_idx: got %0d expected %0d", g, e); end
        end
        n_checks++; if (o_hex[11:8] !== 4'h5) begin n_fail++; $display("FAIL redisp_hex: got %h expected 5", o_hex[11:8]); end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        predict(seg_tab[4], 4'b0001);
        show(seg_tab[4], 4'b0001, LAT);
        predict(seg_tab[11], 4'b0010);
        show(seg_tab[11], 4'b0010, 8);
        n_checks++; if (got_idx.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", got_idx.size()); end
        else begin
            n_checks++; if (got_pos[0] != LAT || got_pos[1] != LAT) begin n_fail++; $display("FAIL b2b_latency: got %0d,%0d expected %0d", got_pos[0], got_pos[1], LAT); end
            n_checks++; if (got_idx[0] != exp_idx[0] || got_idx[1] != exp_idx[1]) begin n_fail++; $display("FAIL b2b_idx: got %0d,%0d expected %0d,%0d", got_idx[0], got_idx[1], exp_idx[0], exp_idx[1]); end
        end
        n_checks++; if (o_hex !== m_hex || o_valid !== m_valid) begin n_fail++; $display("FAIL b2b_outputs: got %h/%b expected %h/%b", o_hex, o_valid, m_hex, m_valid); end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        show(seg_tab[9], 4'b1000, 3);
        rst = 1'b1;
        show(seg_tab[9], 4'b1000, 1);
        m_hex = '0; m_valid = '0; m_err = '0;
        n_checks++; if (got_idx.size() != 0 || o_upd !== 1'b0) begin n_fail++; $display("FAIL rstmid_upd: got %0d pulses expected 0", got_idx.size()); end
        n_checks++; if (o_hex !== 16'h0 || o_valid !== 4'h0 || o_err !== 4'h0) begin n_fail++; $display("FAIL rstmid_clear: got %h/%b/%b expected 0", o_hex, o_valid, o_err); end
        rst = 1'b0;
        predict(seg_tab[9], 4'b1000);
        show(seg_tab[9], 4'b1000, 8);
        n_checks++; if (got_idx.size() != 1 || got_pos[0] != LAT) begin n_fail++; $display("FAIL rstmid_resettle: got %0d pulses expected 1 at edge %0d", got_idx.size(), LAT); end
        n_checks++; if (o_hex !== m_hex || o_valid !== m_valid) begin n_fail++; $display("FAIL rstmid_value: got %h/%b expected %h/%b", o_hex, o_valid, m_hex, m_valid); end
        clear_sb();
        show(seg_tab[6], 4'b0001, LAT);
        n_checks++; if (o_upd !== 1'b1) begin n_fail++; $display("FAIL rstcommit_pre: got upd=%b expected 1", o_upd); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (o_upd !== 1'b0 || o_upd_idx !== 3'd0) begin n_fail++; $display("FAIL rstcommit_upd: got %b/%0d expected 0/0", o_upd, o_upd_idx); end
        n_checks++; if (o_hex !== 16'h0 || o_valid !== 4'h0 || o_err !== 4'h0) begin n_fail++; $display("FAIL rstcommit_clear: got %h/%b/%b expected 0", o_hex, o_valid, o_err); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_scan();
        test_toggle();
        test_bad_dig();
        test_unrecognised();
        test_redisplay();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
